// File: rtl/segment_writeback_queue_if.sv
// Bundles the execute-side enqueue handshake, the segment write port and queue status.
// The slave modport is the queue itself; master is the execute/writeback side plus the register file.
interface segment_writeback_queue_if #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_seg;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     wb_ready;
    logic [2:0]               write_select;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     write_enable;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic                     bad_seg;

    modport slave (
        input  in_valid, in_seg, in_data, wb_ready,
        output in_ready, write_select, write_data, write_enable,
        output count, full, empty, bad_seg
    );

    modport master (
        output in_valid, in_seg, in_data, wb_ready,
        input  in_ready, write_select, write_data, write_enable,
        input  count, full, empty, bad_seg
    );
endinterface

// File: rtl/segment_writeback_queue.sv
// In-order queue of retiring segment-register writes, drained one per cycle onto the
// segment write port shared by the register file and the segment stall scoreboard.
module segment_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    segment_writeback_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count_q;
    logic                  bad_q;
    logic [2:0]            seg_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic full_w;
    logic empty_w;
    logic offer;
    logic legal_seg;
    logic accept;
    logic illegal;
    logic dequeue;

    // Ready comes from registered count only, so a drain never opens a slot in the same cycle.
    assign full_w    = (count_q == CNT_W'(DEPTH));
    assign empty_w   = (count_q == '0);
    assign offer     = bus.in_valid & ~full_w;
    assign legal_seg = (bus.in_seg < 3'd6);
    assign accept    = offer & legal_seg;
    assign illegal   = offer & ~legal_seg;
    assign dequeue   = ~empty_w & bus.wb_ready;

    assign bus.in_ready     = ~full_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = count_q;
    assign bus.bad_seg      = bad_q;
    assign bus.write_enable = dequeue;
    assign bus.write_select = empty_w ? 3'd0 : seg_mem[head];
    assign bus.write_data   = empty_w ? '0 : data_mem[head];

    // Entry storage is deliberately left unreset; empty forces the outputs to zero instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            seg_mem[tail]  <= bus.in_seg;
            data_mem[tail] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            if (accept) begin
                tail <= tail + PTR_W'(1);
            end
            if (dequeue) begin
                head <= head + PTR_W'(1);
            end
            case ({accept, dequeue})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            bad_q <= illegal;
        end
    end
endmodule

// File: tb/tb_segment_writeback_queue.sv
// Directed, table-driven bench for segment_writeback_queue plus hand-written
// sequences for the illegal-segment, full-with-drain and async-reset cases.
module tb_segment_writeback_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    segment_writeback_queue_if #(.DEPTH(4), .DATA_WIDTH(16)) bus ();

    segment_writeback_queue #(.DEPTH(4), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        in_valid;
        logic [2:0]  in_seg;
        logic [15:0] in_data;
        logic        wb_ready;
        logic        exp_we;
        logic [2:0]  exp_sel;
        logic [15:0] exp_data;
        logic [2:0]  exp_count;
        logic        exp_full;
        logic        exp_empty;
        logic        exp_ready;
        logic        exp_bad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic v, logic [2:0] seg, logic [15:0] d, logic wb,
                                logic we, logic [2:0] sel, logic [15:0] wd, logic [2:0] cnt,
                                logic bad);
        vec_t r;
        r.name      = name;
        r.in_valid  = v;
        r.in_seg    = seg;
        r.in_data   = d;
        r.wb_ready  = wb;
        r.exp_we    = we;
        r.exp_sel   = sel;
        r.exp_data  = wd;
        r.exp_count = cnt;
        r.exp_full  = (cnt == 3'd4);
        r.exp_empty = (cnt == 3'd0);
        r.exp_ready = (cnt != 3'd4);
        r.exp_bad   = bad;
        return r;
    endfunction

    task automatic checkField(string name, string field, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
        end
    endtask

    task automatic applyStimulus(logic v, logic [2:0] seg, logic [15:0] d, logic wb);
        bus.in_valid = v;
        bus.in_seg   = seg;
        bus.in_data  = d;
        bus.wb_ready = wb;
    endtask

    task automatic checkOutput(vec_t e);
        checkField(e.name, "write_enable", 32'(bus.write_enable), 32'(e.exp_we));
        checkField(e.name, "write_select", 32'(bus.write_select), 32'(e.exp_sel));
        checkField(e.name, "write_data",   32'(bus.write_data),   32'(e.exp_data));
        checkField(e.name, "count",        32'(bus.count),        32'(e.exp_count));
        checkField(e.name, "full",         32'(bus.full),         32'(e.exp_full));
        checkField(e.name, "empty",        32'(bus.empty),        32'(e.exp_empty));
        checkField(e.name, "in_ready",     32'(bus.in_ready),     32'(e.exp_ready));
        checkField(e.name, "bad_seg",      32'(bus.bad_seg),      32'(e.exp_bad));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic runVector(vec_t e);
        applyStimulus(e.in_valid, e.in_seg, e.in_data, e.wb_ready);
        #1;
        checkOutput(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0);

        vecs.push_back(mk("reset_idle", 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0));
        vecs.push_back(mk("single_in",  1, 3, 16'h0010, 1, 0, 0, 16'h0,    0, 0));
        vecs.push_back(mk("single_wr",  0, 0, 16'h0,    1, 1, 3, 16'h0010, 1, 0));
        vecs.push_back(mk("single_end", 0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 0));
        vecs.push_back(mk("fill_es",    1, 0, 16'h0001, 0, 0, 0, 16'h0,    0, 0));
        vecs.push_back(mk("fill_cs",    1, 1, 16'h0002, 0, 0, 0, 16'h0001, 1, 0));
        vecs.push_back(mk("fill_ss",    1, 2, 16'h0003, 0, 0, 0, 16'h0001, 2, 0));
        vecs.push_back(mk("fill_ds",    1, 3, 16'h0004, 0, 0, 0, 16'h0001, 3, 0));
        vecs.push_back(mk("fifth_rej",  1, 4, 16'h0005, 0, 0, 0, 16'h0001, 4, 0));
        vecs.push_back(mk("drain0",     0, 0, 16'h0,    1, 1, 0, 16'h0001, 4, 0));
        vecs.push_back(mk("drain1",     0, 0, 16'h0,    1, 1, 1, 16'h0002, 3, 0));
        vecs.push_back(mk("drain2",     0, 0, 16'h0,    1, 1, 2, 16'h0003, 2, 0));
        vecs.push_back(mk("drain3",     0, 0, 16'h0,    1, 1, 3, 16'h0004, 1, 0));
        vecs.push_back(mk("drain_done", 0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 0));
        // Streaming: entry k has seg (k+5)%6 and data 0x100+k; keep two in flight for ten cycles.
        vecs.push_back(mk("stream_pre0", 1, 5, 16'h0100, 0, 0, 0, 16'h0,    0, 0));
        vecs.push_back(mk("stream_pre1", 1, 0, 16'h0101, 0, 0, 5, 16'h0100, 1, 0));
        for (int j = 0; j < 10; j++) begin
            vecs.push_back(mk($sformatf("stream%0d", j), 1, 3'((j + 7) % 6), 16'(16'h0102 + j),
                              1, 1, 3'((j + 5) % 6), 16'(16'h0100 + j), 2, 0));
        end
        vecs.push_back(mk("stream_tail0", 0, 0, 16'h0, 1, 1, 3'(15 % 6), 16'h010A, 2, 0));
        vecs.push_back(mk("stream_tail1", 0, 0, 16'h0, 1, 1, 3'(16 % 6), 16'h010B, 1, 0));
        vecs.push_back(mk("stream_done",  0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0));

        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) runVector(vecs[i]);

        // Illegal segment is consumed but not stored; bad_seg pulses for one cycle.
        runVector(mk("illegal_in",   1, 7, 16'hFFFF, 1, 0, 0, 16'h0, 0, 0));
        runVector(mk("illegal_bad",  0, 0, 16'h0,    1, 0, 0, 16'h0, 0, 1));
        runVector(mk("illegal_done", 0, 0, 16'h0,    1, 0, 0, 16'h0, 0, 0));

        // Full queue with a simultaneous drain: input refused this cycle, taken the next.
        runVector(mk("ff_fill0", 1, 0, 16'h0011, 0, 0, 0, 16'h0,    0, 0));
        runVector(mk("ff_fill1", 1, 1, 16'h0012, 0, 0, 0, 16'h0011, 1, 0));
        runVector(mk("ff_fill2", 1, 2, 16'h0013, 0, 0, 0, 16'h0011, 2, 0));
        runVector(mk("ff_fill3", 1, 3, 16'h0014, 0, 0, 0, 16'h0011, 3, 0));
        runVector(mk("ff_both",  1, 2, 16'h00AA, 1, 1, 0, 16'h0011, 4, 0));
        runVector(mk("ff_take",  1, 2, 16'h00AA, 1, 1, 1, 16'h0012, 3, 0));
        runVector(mk("ff_d2",    0, 0, 16'h0,    1, 1, 2, 16'h0013, 3, 0));
        runVector(mk("ff_d3",    0, 0, 16'h0,    1, 1, 3, 16'h0014, 2, 0));
        runVector(mk("ff_daa",   0, 0, 16'h0,    1, 1, 2, 16'h00AA, 1, 0));
        runVector(mk("ff_done",  0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 0));

        // Asynchronous reset between edges with three entries held.
        runVector(mk("rst_fill0", 1, 4, 16'h0021, 0, 0, 0, 16'h0,    0, 0));
        runVector(mk("rst_fill1", 1, 5, 16'h0022, 0, 0, 4, 16'h0021, 1, 0));
        runVector(mk("rst_fill2", 1, 1, 16'h0023, 0, 0, 4, 16'h0021, 2, 0));
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
        #2;
        checkOutput(mk("rst_pre", 0, 0, 16'h0, 1, 1, 4, 16'h0021, 3, 0));
        reset = 1'b0;
        #1;
        checkOutput(mk("rst_async", 0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0));
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        runVector(mk("rst_after0", 0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0));
        runVector(mk("rst_after1", 0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
